uart_rx_fsm: RTL and testbench

Frame-level controller for the UART receiver. It detects the start edge on `rx_in` and enables the bit/edge counter. It sequences the start, data, parity and stop phases from the counter's `edge_cnt`/`bit_cnt`, captures the data sampler's `sampled_bit`, and performs the glitch, parity and stop checks. It sits between the RX pin synchroniser, the bit/edge counter and the data sampler, and drives the parallel-data output of the receiver.

---
 rtl/uart_rx_fsm.sv | 137 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// Frame-level controller of the UART receiver: start detection, phase sequencing,
// data capture and glitch/parity/stop checking, with the parallel data output.
module uart_rx_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic [5:0]        prescale,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [5:0]        edge_cnt,
  input  logic [3:0]        bit_cnt,
  input  logic              sampled_bit,
  output logic              edge_en,
  output logic              dat_samp_en,
  output logic              end_frame,
  output logic [5:0]        prescale_edge,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W + 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [DATA_W-1:0] p_data_nxt;
  logic [5:0]        prescale_nxt;
  logic              par_err_nxt, stp_err_nxt, data_valid_nxt;
  logic [5:0]        cp, last;
  logic              at_cp, at_last;

  // Received parity bit against the captured data; odd parity inverts the sense.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic              par_bit,
                                           input logic              odd);
    return par_bit ^ (^data) ^ odd;
  endfunction

  // First valid sample point of each bit, and its final edge.
  assign cp      = {1'b0, prescale_edge[5:1]} + 6'd2;
  assign last    = prescale_edge - 6'd1;
  assign at_cp   = (edge_cnt == cp);
  assign at_last = (edge_cnt == last);

  assign edge_en     = (state != IDLE);
  assign dat_samp_en = edge_en;

  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift_reg;
    p_data_nxt     = p_data;
    prescale_nxt   = prescale_edge;
    par_err_nxt    = par_err;
    stp_err_nxt    = stp_err;
    data_valid_nxt = 1'b0;
    end_frame      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_in) begin
          state_nxt    = START;
          prescale_nxt = prescale;
          par_err_nxt  = 1'b0;
          stp_err_nxt  = 1'b0;
        end
      end
      START: begin
        if (at_cp && sampled_bit) begin
          state_nxt = IDLE;
          end_frame = 1'b1;
        end else if (at_last) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (at_cp) begin
          shift_nxt = {sampled_bit, shift_reg[DATA_W-1:1]};
        end
        if (at_last && (bit_cnt == LAST_DATA_BIT)) begin
          state_nxt = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_cp) begin
          par_err_nxt = parity_mismatch(shift_reg, sampled_bit, par_typ);
        end
        if (at_last) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at CP keeps the back half of the stop bit open for the next start edge.
        if (at_cp) begin
          stp_err_nxt = ~sampled_bit;
          end_frame   = 1'b1;
          state_nxt   = IDLE;
          if (!par_err && sampled_bit) begin
            p_data_nxt     = shift_reg;
            data_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shift_reg     <= '0;
      p_data        <= '0;
      prescale_edge <= '0;
      par_err       <= 1'b0;
      stp_err       <= 1'b0;
      data_valid    <= 1'b0;
    end else begin
      state         <= state_nxt;
      shift_reg     <= shift_nxt;
      p_data        <= p_data_nxt;
      prescale_edge <= prescale_nxt;
      par_err       <= par_err_nxt;
      stp_err       <= stp_err_nxt;
      data_valid    <= data_valid_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: serial frames with a bit/edge counter stand-in around the DUT,
// checked against frame-level expectations derived from timing and parity arithmetic.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       edge_en, dat_samp_en, end_frame, data_valid, par_err, stp_err;
  logic [5:0] prescale_edge;
  logic [7:0] p_data;

  uart_rx_fsm #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .par_typ(par_typ), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
    .edge_en(edge_en), .dat_samp_en(dat_samp_en), .end_frame(end_frame),
    .prescale_edge(prescale_edge), .p_data(p_data), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit/edge counter stand-in: counts edges per bit while enabled, cleared by end_frame.
  logic [5:0] ec;
  logic [3:0] bk;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ec <= '0;
      bk <= '0;
    end else if (!edge_en || end_frame) begin
      ec <= '0;
      bk <= '0;
    end else if (ec == prescale_edge - 6'd1) begin
      ec <= '0;
      bk <= bk + 4'd1;
    end else begin
      ec <= ec + 6'd1;
    end
  end
  assign edge_cnt    = ec;
  assign bit_cnt     = (ec == prescale_edge - 6'd1) ? bk + 4'd1 : bk;
  assign sampled_bit = rx_in;

  int         ef_q[$];
  int         dv_q[$];
  logic [7:0] dvd_q[$];
  always @(negedge clk) begin
    if (end_frame) ef_q.push_back(cyc);
    if (data_valid) begin
      dv_q.push_back(cyc);
      dvd_q.push_back(p_data);
    end
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_pdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  // Serialises one frame; each queue entry is the line value for one clock.
  task automatic send_frame(input int P, input logic [7:0] data, input bit pe, input bit pt,
                            input bit flip, input bit stopv, input int max_slots,
                            input int chg_slot, input logic [5:0] chg_val, output int t);
    logic q[$];
    logic pb;
    int   cp;
    cp      = P / 2 + 2;
    pb      = (^data) ^ pt ^ flip;
    par_en  = pe;
    par_typ = pt;
    repeat (P) q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (P) q.push_back(data[i]);
    if (pe) repeat (P) q.push_back(pb);
    repeat (cp + 2) q.push_back(stopv);
    t = cyc + 1;
    for (int i = 0; i < q.size() && i != max_slots; i++) begin
      if (i == chg_slot) prescale = chg_val;
      rx_in = q[i];
      step();
    end
  endtask

  task automatic check_frame(input string nm, input int t, input int P, input logic [7:0] data,
                             input bit pe, input bit pt, input bit flip, input bit stopv);
    int   cp, pen, s0, ones;
    logic pb, exp_par, exp_stp, good;
    cp      = P / 2 + 2;
    pen     = pe ? 1 : 0;
    s0      = t + P * (9 + pen) + cp;
    pb      = (^data) ^ pt ^ flip;
    ones    = $countones(data) + (pb ? 1 : 0);
    exp_par = pe && ((ones % 2) != (pt ? 1 : 0));
    exp_stp = !stopv;
    good    = !exp_par && stopv;
    if (good) exp_pdata = data;
    @(negedge clk);
    #1;
    chk({nm, ".ef_n"}, 32'(ef_q.size()), 32'd1);
    if (ef_q.size() > 0) chk({nm, ".ef_cyc"}, 32'(ef_q[0]), 32'(s0));
    chk({nm, ".dv_n"}, 32'(dv_q.size()), good ? 32'd1 : 32'd0);
    if (good && dv_q.size() > 0) begin
      chk({nm, ".dv_cyc"}, 32'(dv_q[0]), 32'(s0 + 1));
      chk({nm, ".dv_data"}, 32'(dvd_q[0]), 32'(data));
    end
    chk({nm, ".dv_now"}, 32'(data_valid), 32'(good));
    chk({nm, ".p_data"}, 32'(p_data), 32'(exp_pdata));
    chk({nm, ".par_err"}, 32'(par_err), 32'(exp_par));
    chk({nm, ".stp_err"}, 32'(stp_err), 32'(exp_stp));
    chk({nm, ".edge_en"}, 32'(edge_en), 32'd0);
    chk({nm, ".pscale"}, 32'(prescale_edge), 32'(P));
    ef_q.delete();
    dv_q.delete();
    dvd_q.delete();
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".edge_en"}, 32'(edge_en), 32'd0);
    chk({nm, ".samp_en"}, 32'(dat_samp_en), 32'd0);
    chk({nm, ".end_frame"}, 32'(end_frame), 32'd0);
    chk({nm, ".p_data"}, 32'(p_data), 32'd0);
    chk({nm, ".dv"}, 32'(data_valid), 32'd0);
    chk({nm, ".par_err"}, 32'(par_err), 32'd0);
    chk({nm, ".stp_err"}, 32'(stp_err), 32'd0);
    chk({nm, ".pscale"}, 32'(prescale_edge), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int         t, P, gap, cslot;
  logic [7:0] d;
  logic [5:0] cval;
  bit         pe, pt, fl, sv;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(4);

    // 8N1 good frame
    prescale = 6'd8;
    send_frame(8, 8'hA5, 0, 0, 0, 1, -1, -1, 6'd0, t);
    check_frame("8n1", t, 8, 8'hA5, 0, 0, 0, 1);
    idle(5);

    // 8E1 good, then bad parity
    prescale = 6'd16;
    send_frame(16, 8'h3C, 1, 0, 0, 1, -1, -1, 6'd0, t);
    check_frame("8e1_ok", t, 16, 8'h3C, 1, 0, 0, 1);
    idle(3);
    send_frame(16, 8'h3C, 1, 0, 1, 1, -1, -1, 6'd0, t);
    check_frame("8e1_bad", t, 16, 8'h3C, 1, 0, 1, 1);
    idle(3);

    // Start glitch: two low clocks at prescale 16
    t = cyc + 1;
    rx_in = 1'b0;
    step();
    step();
    idle(20);
    @(negedge clk);
    #1;
    chk("glitch.ef_n", 32'(ef_q.size()), 32'd1);
    if (ef_q.size() > 0) chk("glitch.ef_cyc", 32'(ef_q[0]), 32'(t + 10));
    chk("glitch.dv_n", 32'(dv_q.size()), 32'd0);
    chk("glitch.par_err", 32'(par_err), 32'd0);
    chk("glitch.stp_err", 32'(stp_err), 32'd0);
    chk("glitch.edge_en", 32'(edge_en), 32'd0);
    chk("glitch.p_data", 32'(p_data), 32'(exp_pdata));
    ef_q.delete();
    dv_q.delete();
    dvd_q.delete();
    idle(2);

    // Stop error at prescale 32
    prescale = 6'd32;
    send_frame(32, 8'h81, 0, 0, 0, 0, -1, -1, 6'd0, t);
    check_frame("stop_err", t, 32, 8'h81, 0, 0, 0, 0);
    idle(4);

    // Back-to-back, prescale changed 8 -> 16 inside frame 1
    prescale = 6'd8;
    send_frame(8, 8'h55, 0, 0, 0, 1, -1, 30, 6'd16, t);
    check_frame("b2b_1", t, 8, 8'h55, 0, 0, 0, 1);
    send_frame(16, 8'hAA, 0, 0, 0, 1, -1, -1, 6'd0, t);
    check_frame("b2b_2", t, 16, 8'hAA, 0, 0, 0, 1);
    idle(4);

    // Reset in the middle of data bit 4
    prescale = 6'd16;
    send_frame(16, 8'h96, 0, 0, 0, 1, 5 * 16 + 8, -1, 6'd0, t);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_pdata = 8'h00;
    rx_in = 1'b1;
    step();
    step();
    rst = 1'b1;
    idle(5);
    chk("midrst.dv_n", 32'(dv_q.size()), 32'd0);
    ef_q.delete();
    dv_q.delete();
    dvd_q.delete();
    send_frame(16, 8'h5A, 0, 0, 0, 1, -1, -1, 6'd0, t);
    check_frame("after_rst", t, 16, 8'h5A, 0, 0, 0, 1);
    idle(3);

    // Randomised frames
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0:       P = 8;
        1:       P = 16;
        default: P = 32;
      endcase
      case ($urandom_range(0, 2))
        0:       cval = 6'd8;
        1:       cval = 6'd16;
        default: cval = 6'd32;
      endcase
      d        = 8'($urandom);
      pe       = ($urandom_range(0, 1) == 1);
      pt       = ($urandom_range(0, 1) == 1);
      fl       = ($urandom_range(0, 3) == 0);
      sv       = ($urandom_range(0, 3) != 0);
      cslot    = int'($urandom_range(10, 60));
      gap      = int'($urandom_range(0, 3));
      prescale = 6'(P);
      send_frame(P, d, pe, pt, fl, sv, -1, cslot, cval, t);
      check_frame("rand", t, P, d, pe, pt, fl, sv);
      idle(gap);
    end

    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
